// File: rtl/tdm_pkg.sv
// ============================================================================
// tdm_pkg : shared constants and state type for the 1:8 TDM demultiplexer
// Rev 1.0 ; TDM_DEMUX_PARITY_EN adds a ninth (even parity) slot per frame
// ============================================================================
`default_nettype none

package tdm_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_SLOTS = 9;
`else
  localparam int FRAME_SLOTS = 8;
`endif

  localparam int CTR_W = $clog2(FRAME_SLOTS);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
// ============================================================================
// tdm_slot_ctr : frame slot counter with wrap, sync restart and last-slot flag
// Rev 1.0 ; frame length follows TDM_DEMUX_PARITY_EN via tdm_pkg
// ============================================================================
`default_nettype none

module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             advance,
  output logic [CTR_W-1:0] cnt,
  output logic             last_slot
);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  assign last_slot = (cnt_q == CTR_W'(FRAME_SLOTS - 1));
  assign cnt       = cnt_q;

  // A final slot always closes the frame, even when restart arrives with it.
  always_comb begin
    cnt_d = cnt_q;
    if (advance && last_slot) begin
      cnt_d = '0;
    end else if (restart) begin
      cnt_d = advance ? CTR_W'(1) : '0;
    end else if (advance) begin
      cnt_d = cnt_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdm_demux_eight.sv
// ============================================================================
// tdm_demux_eight : 1:8 TDM slot demultiplexer presenting whole frames in parallel
// Rev 1.0 ; define TDM_DEMUX_PARITY_EN for a ninth even-parity slot per frame
// ============================================================================
`default_nettype none

module tdm_demux_eight
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 sync,
  output logic [NCH*WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic [SEL_W-1:0]     sel,
  output logic                 frame_err,
  output logic                 parity_err
);

  state_e               state_q, state_d;
  logic [NCH*WIDTH-1:0] shadow_q, shadow_d;
  logic [NCH*WIDTH-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;

  logic [CTR_W-1:0]     cnt;
  logic                 last_slot;
  logic                 accept;
  logic                 complete;
  logic                 wr_shadow;
  logic [SEL_W-1:0]     wr_slot;

  // In HUNT only a sync-marked slot is taken; in RUN every valid slot is.
  assign accept   = din_valid && ((state_q == RUN) || sync);
  assign complete = accept && last_slot;
  assign wr_slot  = (sync && !complete) ? '0 : cnt[SEL_W-1:0];

`ifdef TDM_DEMUX_PARITY_EN
  assign wr_shadow = accept && !complete;
  assign sel       = last_slot ? '0 : cnt[SEL_W-1:0];
`else
  assign wr_shadow = accept;
  assign sel       = cnt;
`endif

  tdm_slot_ctr u_slot_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (sync),
    .advance   (accept),
    .cnt       (cnt),
    .last_slot (last_slot)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (wr_shadow) begin
      shadow_d[wr_slot*WIDTH +: WIDTH] = din;
    end

    state_d = state_q;
    if ((state_q == HUNT) && sync) begin
      state_d = RUN;
    end

    // shadow_d already holds the merged final channel on a completing slot.
    dout_d       = complete ? shadow_d : dout_q;
    dout_valid_d = complete;
    frame_err_d  = (state_q == RUN) && sync && (cnt != '0) && !complete;

`ifdef TDM_DEMUX_PARITY_EN
    parity_err_d = complete && ((^shadow_q) ^ (^din));
`else
    parity_err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

`default_nettype wire
